// File: rtl/destuffer_if.sv
// rtl/destuffer_if.sv - line-side and data-side signal bundle for the bit destuffer
//
// Signals:
//   enable    1  global advance enable; low freezes the destuffer
//   rxin      1  serial line, synchronous to clk
//   baudrate  8  clocks per bit period (0 behaves as 1)
//   rxout     1  last destuffed data bit
//   rxvalid   1  one-cycle strobe: new data bit on rxout
//   stufferr  1  one-cycle strobe: stuff bit failed to toggle
//   errcount  8  saturating stuff error count
// Modports:
//   master  drives line/config, observes destuffed output (receiver side)
//   slave   the destuffer itself
interface destuffer_if;
    logic       enable;
    logic       rxin;
    logic [7:0] baudrate;
    logic       rxout;
    logic       rxvalid;
    logic       stufferr;
    logic [7:0] errcount;

    modport master (
        output enable, rxin, baudrate,
        input  rxout, rxvalid, stufferr, errcount
    );

    modport slave (
        input  enable, rxin, baudrate,
        output rxout, rxvalid, stufferr, errcount
    );
endinterface

// File: rtl/destuffer.sv
// rtl/destuffer.sv - receive-side bit destuffer with baud sampling and stuff error count
//
// Samples rxin once per bit period, tracks runs of identical bits and drops
// the complement stuff bit that follows RUNLEN identical data bits. A stuff
// bit that repeats the previous bit is flagged on stufferr and counted.
//
// Ports:
//   clk      1  rising-edge clock
//   reset_n  1  asynchronous active-low reset
//   bus         destuffer_if.slave (enable, rxin, baudrate in;
//               rxout, rxvalid, stufferr, errcount out)
// Parameters:
//   RUNLEN   identical bits before a stuff bit is expected, 2..7
module destuffer #(
    parameter int RUNLEN = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    destuffer_if.slave  bus
);

    localparam logic [2:0] RUN_MAX = 3'(RUNLEN);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_DATA  = 2'd1,
        ST_STUFF = 2'd2
    } run_state_t;

    logic [7:0] baudcnt, baudcnt_d;
    logic [2:0] runcnt, runcnt_d;
    logic       lastbit, lastbit_d;
    logic       rxout_q, rxout_d;
    logic       rxvalid_q, rxvalid_d;
    logic       stufferr_q, stufferr_d;
    logic [7:0] errcount_q, errcount_d;

    run_state_t st;
    logic       sample;
    logic       s;

    // The >= compare makes baudrate 0/1 sample every enabled cycle and lets a
    // runtime decrease below the current count sample on the next enabled cycle.
    assign sample = bus.enable && (baudcnt >= bus.baudrate);
    assign s      = bus.rxin;

    // The run state is fully encoded in runcnt.
    always_comb begin
        if (runcnt == 3'd0)
            st = ST_HUNT;
        else if (runcnt == RUN_MAX)
            st = ST_STUFF;
        else
            st = ST_DATA;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baudcnt    <= 8'd1;
            runcnt     <= 3'd0;
            lastbit    <= 1'b0;
            rxout_q    <= 1'b0;
            rxvalid_q  <= 1'b0;
            stufferr_q <= 1'b0;
            errcount_q <= 8'd0;
        end else begin
            baudcnt    <= baudcnt_d;
            runcnt     <= runcnt_d;
            lastbit    <= lastbit_d;
            rxout_q    <= rxout_d;
            rxvalid_q  <= rxvalid_d;
            stufferr_q <= stufferr_d;
            errcount_q <= errcount_d;
        end
    end

    // Next-state logic: baud counter and run tracking
    always_comb begin
        baudcnt_d = baudcnt;
        runcnt_d  = runcnt;
        lastbit_d = lastbit;

        if (bus.enable) begin
            if (sample)
                baudcnt_d = 8'd1;
            else
                baudcnt_d = baudcnt + 8'd1;
        end

        if (sample) begin
            case (st)
                ST_HUNT: begin
                    lastbit_d = s;
                    runcnt_d  = 3'd1;
                end
                ST_DATA: begin
                    if (s == lastbit) begin
                        runcnt_d = runcnt + 3'd1;
                    end else begin
                        lastbit_d = s;
                        runcnt_d  = 3'd1;
                    end
                end
                ST_STUFF: begin
                    lastbit_d = s;
                    // A good stuff bit opens the next run; a bad one drops
                    // all history so the line is re-acquired from scratch.
                    runcnt_d  = (s != lastbit) ? 3'd1 : 3'd0;
                end
                default: begin
                    runcnt_d = 3'd0;
                end
            endcase
        end
    end

    // Output logic: values registered on the next edge
    always_comb begin
        rxout_d    = rxout_q;
        rxvalid_d  = 1'b0;
        stufferr_d = 1'b0;
        errcount_d = errcount_q;

        if (sample) begin
            case (st)
                ST_HUNT, ST_DATA: begin
                    rxout_d   = s;
                    rxvalid_d = 1'b1;
                end
                ST_STUFF: begin
                    if (s == lastbit) begin
                        stufferr_d = 1'b1;
                        if (errcount_q != 8'hFF)
                            errcount_d = errcount_q + 8'd1;
                    end
                end
                default: begin
                    rxvalid_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.rxout    = rxout_q;
    assign bus.rxvalid  = rxvalid_q;
    assign bus.stufferr = stufferr_q;
    assign bus.errcount = errcount_q;

endmodule

// File: tb/tb_destuffer.sv
// tb/tb_destuffer.sv - directed self-checking bench for destuffer
module tb_destuffer;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    destuffer_if bus ();

    destuffer #(.RUNLEN(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Step n clocks, observing outputs 1 time unit after each rising edge.
    task automatic run_clocks(input int n, output int nv, output int ne,
                              output int nb, output int pos, output logic rx);
        nv = 0; ne = 0; nb = 0; pos = 0; rx = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (bus.rxvalid) begin
                nv++;
                pos = i;
                rx  = bus.rxout;
            end
            if (bus.stufferr) begin
                ne++;
                pos = i;
            end
            if (bus.rxvalid && bus.stufferr)
                nb++;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        int nv, ne, nb, pos;
        logic rx;
        reset_n      = 1'b0;
        bus.enable   = 1'b1;
        bus.baudrate = 8'd4;
        bus.rxin     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.rxout !== 1'b0) begin n_fail++; $display("FAIL reset_rxout: got %b expected 0", bus.rxout); end
        n_checks++; if (bus.rxvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rxvalid: got %b expected 0", bus.rxvalid); end
        n_checks++; if (bus.stufferr !== 1'b0) begin n_fail++; $display("FAIL reset_stufferr: got %b expected 0", bus.stufferr); end
        n_checks++; if (bus.errcount !== 8'd0) begin n_fail++; $display("FAIL reset_errcount: got %0d expected 0", bus.errcount); end
        reset_n = 1'b1;
        run_clocks(4, nv, ne, nb, pos, rx);
        n_checks++; if (nv != 1) begin n_fail++; $display("FAIL first_valid_count: got %0d expected 1", nv); end
        n_checks++; if (pos != 4) begin n_fail++; $display("FAIL first_valid_latency: got %0d expected 4", pos); end
        n_checks++; if (rx !== 1'b1) begin n_fail++; $display("FAIL first_rxout: got %b expected 1", rx); end
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        n_checks++; if (bus.rxout !== 1'b0) begin n_fail++; $display("FAIL async_reset_rxout: got %b expected 0", bus.rxout); end
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_alternate();
        int nv, ne, nb, pos;
        logic rx;
        logic bits [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        apply_reset();
        bus.baudrate = 8'd4;
        for (int i = 0; i < 4; i++) begin
            bus.rxin = bits[i];
            run_clocks(4, nv, ne, nb, pos, rx);
            n_checks++; if (nv != 1) begin n_fail++; $display("FAIL alt_valid[%0d]: got %0d expected 1", i, nv); end
            n_checks++; if (pos != 4) begin n_fail++; $display("FAIL alt_spacing[%0d]: got %0d expected 4", i, pos); end
            n_checks++; if (rx !== bits[i]) begin n_fail++; $display("FAIL alt_rxout[%0d]: got %b expected %b", i, rx, bits[i]); end
            n_checks++; if (ne != 0) begin n_fail++; $display("FAIL alt_stufferr[%0d]: got %0d expected 0", i, ne); end
        end
    endtask

    task automatic test_stuff();
        int nv, ne, nb, pos;
        logic rx;
        logic line  [18] = '{1,1,1,1,1, 0, 1,1,1,1,1, 0, 0,0,0,0, 1, 1};
        int   exp_v [18] = '{1,1,1,1,1, 0, 1,1,1,1,1, 0, 1,1,1,1, 0, 1};
        apply_reset();
        bus.baudrate = 8'd4;
        for (int i = 0; i < 18; i++) begin
            bus.rxin = line[i];
            run_clocks(4, nv, ne, nb, pos, rx);
            n_checks++; if (nv != exp_v[i]) begin n_fail++; $display("FAIL stuff_valid[%0d]: got %0d expected %0d", i, nv, exp_v[i]); end
            n_checks++; if (ne != 0) begin n_fail++; $display("FAIL stuff_err[%0d]: got %0d expected 0", i, ne); end
            if (exp_v[i] == 1) begin
                n_checks++; if (rx !== line[i]) begin n_fail++; $display("FAIL stuff_rxout[%0d]: got %b expected %b", i, rx, line[i]); end
            end
        end
        n_checks++; if (bus.rxout !== 1'b1) begin n_fail++; $display("FAIL stuff_hold_rxout: got %b expected 1", bus.rxout); end
    endtask

    task automatic test_stuff_error();
        int nv, ne, nb, pos;
        logic rx;
        int tot_v, tot_e, tot_b;
        apply_reset();
        bus.baudrate = 8'd2;
        bus.rxin     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_clocks(2, nv, ne, nb, pos, rx);
            n_checks++; if (nv != 1 || rx !== 1'b0) begin n_fail++; $display("FAIL err_data[%0d]: got valid=%0d rx=%b expected valid=1 rx=0", i, nv, rx); end
        end
        run_clocks(2, nv, ne, nb, pos, rx);
        n_checks++; if (ne != 1) begin n_fail++; $display("FAIL err_strobe: got %0d expected 1", ne); end
        n_checks++; if (nv != 0) begin n_fail++; $display("FAIL err_no_valid: got %0d expected 0", nv); end
        n_checks++; if (bus.errcount !== 8'd1) begin n_fail++; $display("FAIL err_count1: got %0d expected 1", bus.errcount); end
        bus.rxin = 1'b1;
        run_clocks(2, nv, ne, nb, pos, rx);
        n_checks++; if (nv != 1 || rx !== 1'b1 || ne != 0) begin n_fail++; $display("FAIL err_hunt: got valid=%0d rx=%b err=%0d expected valid=1 rx=1 err=0", nv, rx, ne); end
        tot_v = 0; tot_e = 0; tot_b = 0;
        bus.rxin = 1'b0;
        for (int k = 0; k < 256; k++) begin
            for (int j = 0; j < 6; j++) begin
                run_clocks(2, nv, ne, nb, pos, rx);
                tot_v += nv; tot_e += ne; tot_b += nb;
            end
        end
        n_checks++; if (tot_e != 256) begin n_fail++; $display("FAIL sat_err_strobes: got %0d expected 256", tot_e); end
        n_checks++; if (tot_v != 1280) begin n_fail++; $display("FAIL sat_valid_strobes: got %0d expected 1280", tot_v); end
        n_checks++; if (tot_b != 0) begin n_fail++; $display("FAIL sat_both_strobes: got %0d expected 0", tot_b); end
        n_checks++; if (bus.errcount !== 8'd255) begin n_fail++; $display("FAIL sat_errcount: got %0d expected 255", bus.errcount); end
    endtask

    task automatic test_reset_midrun();
        int nv, ne, nb, pos;
        logic rx;
        bus.baudrate = 8'd4;
        bus.rxin     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_clocks(4, nv, ne, nb, pos, rx);
            n_checks++; if (nv != 1 || rx !== 1'b1) begin n_fail++; $display("FAIL pre_reset_one[%0d]: got valid=%0d rx=%b expected valid=1 rx=1", i, nv, rx); end
        end
        run_clocks(2, nv, ne, nb, pos, rx);
        n_checks++; if (nv + ne != 0) begin n_fail++; $display("FAIL midbit_quiet: got %0d strobes expected 0", nv + ne); end
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        n_checks++; if (bus.errcount !== 8'd0) begin n_fail++; $display("FAIL midrun_errcount: got %0d expected 0", bus.errcount); end
        n_checks++; if (bus.rxout !== 1'b0) begin n_fail++; $display("FAIL midrun_rxout: got %b expected 0", bus.rxout); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_clocks(4, nv, ne, nb, pos, rx);
            n_checks++; if (nv != 1 || ne != 0 || rx !== 1'b1) begin n_fail++; $display("FAIL post_reset_one[%0d]: got valid=%0d err=%0d rx=%b expected valid=1 err=0 rx=1", i, nv, ne, rx); end
        end
        bus.rxin = 1'b0;
        run_clocks(4, nv, ne, nb, pos, rx);
        n_checks++; if (nv != 0 || ne != 0) begin n_fail++; $display("FAIL post_reset_stuff: got valid=%0d err=%0d expected 0 0", nv, ne); end
    endtask

    task automatic test_enable();
        int nv, ne, nb, pos;
        logic rx;
        logic bits [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        bus.baudrate = 8'd4;
        bus.rxin     = 1'b1;
        run_clocks(2, nv, ne, nb, pos, rx);
        n_checks++; if (nv + ne != 0) begin n_fail++; $display("FAIL en_prefix: got %0d strobes expected 0", nv + ne); end
        bus.enable = 1'b0;
        run_clocks(10, nv, ne, nb, pos, rx);
        n_checks++; if (nv + ne != 0) begin n_fail++; $display("FAIL en_frozen: got %0d strobes expected 0", nv + ne); end
        bus.enable = 1'b1;
        run_clocks(2, nv, ne, nb, pos, rx);
        n_checks++; if (nv != 1 || pos != 2 || rx !== 1'b1) begin n_fail++; $display("FAIL en_resume: got valid=%0d pos=%0d rx=%b expected valid=1 pos=2 rx=1", nv, pos, rx); end
        bus.baudrate = 8'd0;
        for (int i = 0; i < 4; i++) begin
            bus.rxin = bits[i];
            run_clocks(1, nv, ne, nb, pos, rx);
            n_checks++; if (nv != 1 || rx !== bits[i]) begin n_fail++; $display("FAIL baud0[%0d]: got valid=%0d rx=%b expected valid=1 rx=%b", i, nv, rx, bits[i]); end
        end
        bus.enable = 1'b0;
        bus.rxin   = 1'b0;
        run_clocks(1, nv, ne, nb, pos, rx);
        n_checks++; if (nv + ne != 0) begin n_fail++; $display("FAIL baud0_disabled: got %0d strobes expected 0", nv + ne); end
        bus.enable = 1'b1;
        run_clocks(1, nv, ne, nb, pos, rx);
        n_checks++; if (nv != 1 || rx !== 1'b0) begin n_fail++; $display("FAIL baud0_reenable: got valid=%0d rx=%b expected valid=1 rx=0", nv, rx); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_alternate();
        test_stuff();
        test_stuff_error();
        test_reset_midrun();
        test_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
